// File: rtl/bconv_stream_engine_if.sv
// Bus bundle for bconv_stream_engine.
//   dut_run                 start request from the host
//   dut_busy                job in progress
//   dut_sram_read_address   input row address   / sram_dut_read_data (1-cycle latency)
//   dut_wmem_read_address   kernel word address / wmem_dut_read_data (1-cycle latency)
//   dut_sram_write_*        output row write port
// Modport slave is the engine's view; master is the host/memory side.
interface bconv_stream_engine_if #(
  parameter int ADDR_W = 12
);
  logic              dut_run;
  logic              dut_busy;
  logic [ADDR_W-1:0] dut_sram_read_address;
  logic [15:0]       sram_dut_read_data;
  logic [ADDR_W-1:0] dut_wmem_read_address;
  logic [15:0]       wmem_dut_read_data;
  logic [ADDR_W-1:0] dut_sram_write_address;
  logic              dut_sram_write_enable;
  logic [15:0]       dut_sram_write_data;

  modport slave (
    input  dut_run, sram_dut_read_data, wmem_dut_read_data,
    output dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_address, dut_sram_write_enable, dut_sram_write_data
  );

  modport master (
    output dut_run, sram_dut_read_data, wmem_dut_read_data,
    input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
           dut_sram_write_address, dut_sram_write_enable, dut_sram_write_data
  );
endinterface

// File: rtl/bconv_stream_engine.sv
// Streaming 3x3 binary convolution engine.
// On dut_run (sampled in IDLE) it fetches DIM input rows from SRAM, one row per
// word, and the 9-bit kernel from WMEM. Each 3x3 window is XNOR-popcounted
// against the kernel and thresholded; one (DIM-2)-bit output row is written per
// SRAM word at OUT_BASE + r, in row order.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; abandons any job and clears all state
//   bus    bconv_stream_engine_if.slave (run/busy, SRAM/WMEM read, SRAM write)
module bconv_stream_engine #(
  parameter int DIM      = 16,
  parameter int THRESH   = 5,
  parameter int ADDR_W   = 12,
  parameter int IN_BASE  = 0,
  parameter int OUT_BASE = 256,
  parameter int W_ADDR   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  bconv_stream_engine_if.slave bus
);

  localparam logic [4:0]        DIM_C      = 5'(DIM);
  localparam logic [15:0]       COL_MASK   = 16'((32'd1 << DIM) - 32'd1);
  localparam logic [ADDR_W-1:0] IN_BASE_A  = ADDR_W'(IN_BASE);
  localparam logic [ADDR_W-1:0] OUT_BASE_A = ADDR_W'(OUT_BASE);
  localparam logic [ADDR_W-1:0] W_ADDR_A   = ADDR_W'(W_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] n;
    n = '0;
    for (int b = 0; b < 9; b++) n = n + {3'b000, v[b]};
    return n;
  endfunction

  function automatic logic thresh_bit(input logic [3:0] cnt);
    return (int'(cnt) >= THRESH);
  endfunction

  // Window bit 3*i+k = row i (0 = oldest) at column j+k, matching kernel layout.
  function automatic logic [8:0] window3x3(input logic [15:0] top,
                                           input logic [15:0] mid,
                                           input logic [15:0] bot,
                                           input int          j);
    return {bot[j+:3], mid[j+:3], top[j+:3]};
  endfunction

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        rows_q, rows_d;
  logic              rd_vld_q, rd_vld_d;
  logic [15:0]       row0_q, row0_d;
  logic [15:0]       row1_q, row1_d;
  logic [8:0]        kern_q, kern_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W-1:0] wmaddr_q, wmaddr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;

  logic [15:0]       in_row;
  logic [15:0]       out_row;
  logic              unused_wmem_hi;

  assign in_row         = bus.sram_dut_read_data & COL_MASK;
  assign unused_wmem_hi = ^bus.wmem_dut_read_data[15:9];

  // Stage 0: incoming row (combinational) plus the two buffered rows form the windows
  always_comb begin
    out_row = '0;
    for (int j = 0; j < 14; j++) begin
      if (j < DIM - 2) begin
        out_row[j] = thresh_bit(popcount9(~(window3x3(row0_q, row1_q, in_row, j) ^ kern_q)));
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rows_d   = rows_q;
    row0_d   = row0_q;
    row1_d   = row1_q;
    kern_d   = kern_q;
    raddr_d  = raddr_q;
    wmaddr_d = wmaddr_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    // Read data is valid exactly one cycle after each FETCH-cycle address.
    rd_vld_d = (state_q == S_FETCH);

    unique case (state_q)
      S_IDLE: begin
        if (bus.dut_run) begin
          state_d  = S_FETCH;
          cnt_d    = 5'd1;
          rows_d   = '0;
          raddr_d  = IN_BASE_A;
          wmaddr_d = W_ADDR_A;
        end
      end
      S_FETCH: begin
        if (cnt_q == DIM_C) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + 5'd1;
          raddr_d = raddr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // Two cycles: last row arrives, then its output row is on the bus.
        if (cnt_q == 5'd1) state_d = S_IDLE;
        else               cnt_d   = cnt_q + 5'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_vld_q) begin
      rows_d = rows_q + 5'd1;
      row0_d = row1_q;
      row1_d = in_row;
      // The kernel word lands together with input row 0.
      if (rows_q == 5'd0) kern_d = bus.wmem_dut_read_data[8:0];
      if (rows_q >= 5'd2) begin
        we_d    = 1'b1;
        waddr_d = OUT_BASE_A + ADDR_W'(rows_q - 5'd2);
        wdata_d = out_row;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  // Stage 1: registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rows_q   <= '0;
      rd_vld_q <= 1'b0;
      row0_q   <= '0;
      row1_q   <= '0;
      kern_q   <= '0;
      busy_q   <= 1'b0;
      raddr_q  <= '0;
      wmaddr_q <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rows_q   <= rows_d;
      rd_vld_q <= rd_vld_d;
      row0_q   <= row0_d;
      row1_q   <= row1_d;
      kern_q   <= kern_d;
      busy_q   <= busy_d;
      raddr_q  <= raddr_d;
      wmaddr_q <= wmaddr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.dut_busy               = busy_q;
  assign bus.dut_sram_read_address  = raddr_q;
  assign bus.dut_wmem_read_address  = wmaddr_q;
  assign bus.dut_sram_write_enable  = we_q;
  assign bus.dut_sram_write_address = waddr_q;
  assign bus.dut_sram_write_data    = wdata_q;

endmodule

// File: tb/tb_bconv_stream_engine.sv
module tb_bconv_stream_engine;

  typedef struct {
    int          inst;
    int          cyc;
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int          inst;
    int          cyc;
    int          kind;
    logic [15:0] val;
  } pr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  run_v;
  logic [15:0] mem [16];
  logic [15:0] kern_w;
  int          cyc = 0;
  int          checks = 0;
  int          fails = 0;
  bit          done = 1'b0;

  wr_t wq[$];
  pr_t pq[$];

  logic [3:0]  busy_a;
  logic [3:0]  we_a;
  logic [11:0] raddr_a  [4];
  logic [11:0] wmaddr_a [4];
  logic [11:0] waddr_a  [4];
  logic [15:0] wdata_a  [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // inst 0: DIM=4 TH=5, inst 1: DIM=3 TH=5, inst 2: DIM=3 TH=6, inst 3: DIM=16 TH=5
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int GD = (g == 0) ? 4 : ((g == 3) ? 16 : 3);
    localparam int GT = (g == 2) ? 6 : 5;

    bconv_stream_engine_if #(.ADDR_W(12)) bus ();

    bconv_stream_engine #(
      .DIM(GD), .THRESH(GT), .ADDR_W(12),
      .IN_BASE(0), .OUT_BASE(256), .W_ADDR(0)
    ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus)
    );

    assign bus.dut_run = run_v[g];

    always @(posedge clk) begin
      bus.sram_dut_read_data <= (bus.dut_sram_read_address < 12'd16) ?
                                mem[bus.dut_sram_read_address[3:0]] : 16'h5A5A;
      bus.wmem_dut_read_data <= (bus.dut_wmem_read_address == 12'd0) ? kern_w : 16'hDEAD;
    end

    assign busy_a[g]   = bus.dut_busy;
    assign we_a[g]     = bus.dut_sram_write_enable;
    assign raddr_a[g]  = bus.dut_sram_read_address;
    assign wmaddr_a[g] = bus.dut_wmem_read_address;
    assign waddr_a[g]  = bus.dut_sram_write_address;
    assign wdata_a[g]  = bus.dut_sram_write_data;
  end

  function automatic logic [15:0] probe_val(int i, int kind);
    case (kind)
      0:       return {15'b0, busy_a[i]};
      1:       return {4'b0, raddr_a[i]};
      2:       return {4'b0, wmaddr_a[i]};
      3:       return {15'b0, we_a[i]};
      4:       return {4'b0, waddr_a[i]};
      default: return wdata_a[i];
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      0:       return "busy";
      1:       return "sram_rd_addr";
      2:       return "wmem_rd_addr";
      3:       return "wr_en";
      4:       return "wr_addr";
      default: return "wr_data";
    endcase
  endfunction

  // Golden row: XNOR-popcount every window straight from the memory image.
  function automatic logic [15:0] model_row(int dim, int th, int r, logic [8:0] k);
    logic [15:0] o;
    int          n;
    o = '0;
    for (int j = 0; j < dim - 2; j++) begin
      n = 0;
      for (int i = 0; i < 3; i++)
        for (int c = 0; c < 3; c++)
          if (mem[r + i][j + c] == k[3 * i + c]) n++;
      if (n >= th) o[j] = 1'b1;
    end
    return o;
  endfunction

  task automatic push_probe(input int inst, input int c, input int kind, input logic [15:0] v);
    pr_t p;
    p.inst = inst; p.cyc = c; p.kind = kind; p.val = v;
    pq.push_back(p);
  endtask

  task automatic push_write(input int inst, input int c, input int addr, input logic [15:0] d);
    wr_t w;
    w.inst = inst; w.cyc = c; w.addr = 12'(addr); w.data = d;
    wq.push_back(w);
  endtask

  // abort > 0: reset lands in cycle 'abort', so the job dies from cycle abort+1.
  task automatic push_job_probes(input int inst, input int c0, input int dim, input int abort);
    for (int c = 1; c <= dim + 3; c++) begin
      if (abort > 0) begin
        push_probe(inst, c0 + c, 0, (c <= abort) ? 16'd1 : 16'd0);
        push_probe(inst, c0 + c, 1, (c <= abort) ? 16'(c - 1) : 16'd0);
        if (c > abort) push_probe(inst, c0 + c, 3, 16'd0);
      end else begin
        push_probe(inst, c0 + c, 0, (c <= dim + 2) ? 16'd1 : 16'd0);
        push_probe(inst, c0 + c, 1, (c <= dim) ? 16'(c - 1) : 16'(dim - 1));
        if (c < 5 || c == dim + 3) push_probe(inst, c0 + c, 3, 16'd0);
      end
      if (c == 1) push_probe(inst, c0 + c, 2, 16'd0);
    end
  endtask

  task automatic start_job(input int inst, input int dim, input int abort, input bit hold,
                           output int c0);
    c0 = cyc;
    run_v[inst] = 1'b1;
    push_job_probes(inst, c0, dim, abort);
    @(negedge clk);
    if (!hold) run_v[inst] = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    pr_t         p;
    wr_t         w;
    logic [15:0] act;
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      p   = pq.pop_front();
      act = probe_val(p.inst, p.kind);
      checks++;
      if (p.cyc != cyc || act !== p.val) begin
        fails++;
        $display("FAIL %s inst=%0d cyc=%0d (at %0d) got=%h want=%h",
                 kname(p.kind), p.inst, p.cyc, cyc, act, p.val);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (we_a[i]) begin
        checks++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write inst=%0d cyc=%0d unexpected addr=%h data=%h",
                   i, cyc, waddr_a[i], wdata_a[i]);
        end else begin
          w = wq.pop_front();
          if (w.inst != i || w.cyc != cyc || w.addr !== waddr_a[i] || w.data !== wdata_a[i]) begin
            fails++;
            $display("FAIL write got inst=%0d cyc=%0d addr=%h data=%h want inst=%0d cyc=%0d addr=%h data=%h",
                     i, cyc, waddr_a[i], wdata_a[i], w.inst, w.cyc, w.addr, w.data);
          end
        end
      end
    end
    if (done || cyc > 20000) begin
      checks++;
      if (!done || wq.size() != 0 || pq.size() != 0) begin
        fails++;
        $display("FAIL drain done=%0d pending_writes=%0d pending_probes=%0d want 1/0/0",
                 done, wq.size(), pq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
    end
  end

  // Stimulus
  initial begin
    int c0;
    logic [15:0] rnd [16];
    rnd = '{16'h3A5C, 16'hF0E1, 16'h9B27, 16'h4D18, 16'hC3F6, 16'h2E9A, 16'h7154, 16'hA8C3,
            16'h5F0D, 16'h16B2, 16'hE47F, 16'h0C99, 16'hB361, 16'h68DE, 16'hD72B, 16'h8F40};
    rst    = 1'b1;
    run_v  = 4'b0;
    kern_w = 16'h0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 6; k++) push_probe(i, cyc + 1, k, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // DIM=4, all-ones kernel, all-ones rows (junk in ignored columns)
    mem[0] = 16'h000F; mem[1] = 16'h000F; mem[2] = 16'hF00F; mem[3] = 16'hA00F;
    kern_w = 16'h01FF;
    start_job(0, 4, 0, 1'b0, c0);
    push_write(0, c0 + 5, 256, 16'h0003);
    push_write(0, c0 + 6, 257, 16'h0003);
    wait_until(c0 + 9);

    // DIM=4, zero kernel -> count 0 everywhere
    kern_w = 16'h0000;
    start_job(0, 4, 0, 1'b0, c0);
    push_write(0, c0 + 5, 256, 16'h0000);
    push_write(0, c0 + 6, 257, 16'h0000);
    wait_until(c0 + 9);

    // DIM=3, count exactly 5: THRESH=5 -> 1, THRESH=6 -> 0
    mem[0] = 16'h0007; mem[1] = 16'h0003; mem[2] = 16'h0000;
    kern_w = 16'hFFFF;
    start_job(1, 3, 0, 1'b0, c0);
    push_write(1, c0 + 5, 256, 16'h0001);
    wait_until(c0 + 8);
    start_job(2, 3, 0, 1'b0, c0);
    push_write(2, c0 + 5, 256, 16'h0000);
    wait_until(c0 + 8);

    // DIM=16 full job against the golden model
    for (int i = 0; i < 16; i++) mem[i] = rnd[i];
    kern_w = 16'hFEB5;
    start_job(3, 16, 0, 1'b0, c0);
    for (int r = 0; r < 14; r++) push_write(3, c0 + 5 + r, 256 + r, model_row(16, 5, r, 9'h0B5));
    wait_until(c0 + 21);

    // Reset in cycle 3 of a DIM=16 job, then a clean job
    start_job(3, 16, 3, 1'b0, c0);
    wait_until(c0 + 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_until(c0 + 22);
    for (int i = 0; i < 16; i++) mem[i] = rnd[i] ^ 16'h5A5A;
    kern_w = 16'h812C;
    start_job(3, 16, 0, 1'b0, c0);
    for (int r = 0; r < 14; r++) push_write(3, c0 + 5 + r, 256 + r, model_row(16, 5, r, 9'h12C));
    wait_until(c0 + 21);

    // dut_run pulsed mid-job is ignored; kernel 0x155, rows 7,E,F,9 -> 0x0001, 0x0002
    mem[0] = 16'h0007; mem[1] = 16'h000E; mem[2] = 16'h000F; mem[3] = 16'h0009;
    kern_w = 16'h0155;
    start_job(0, 4, 0, 1'b0, c0);
    push_write(0, c0 + 5, 256, 16'h0001);
    push_write(0, c0 + 6, 257, 16'h0002);
    wait_until(c0 + 2);
    run_v[0] = 1'b1;
    @(negedge clk);
    run_v[0] = 1'b0;
    for (int c = 8; c <= 12; c++) push_probe(0, c0 + c, 0, 16'd0);
    wait_until(c0 + 14);

    // dut_run held high: second job's cycle 1 follows the first IDLE cycle
    start_job(0, 4, 0, 1'b1, c0);
    push_job_probes(0, c0 + 7, 4, 0);
    push_write(0, c0 + 5, 256, 16'h0001);
    push_write(0, c0 + 6, 257, 16'h0002);
    push_write(0, c0 + 12, 256, 16'h0001);
    push_write(0, c0 + 13, 257, 16'h0002);
    wait_until(c0 + 8);
    run_v[0] = 1'b0;
    for (int c = 15; c <= 17; c++) push_probe(0, c0 + c, 0, 16'd0);
    wait_until(c0 + 19);

    done = 1'b1;
  end

endmodule
